// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-ISA core: 4 GPRs (r0 reads as zero), one shared
// instruction/data memory port with req/ready handshake, sticky halt and
// a retired-instruction counter.
module multicycle_cpu #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted,
    output logic [31:0]       retired
);

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned IMM_W    = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;

    localparam logic [15:0] HALT_INSN = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic              halted_q, halted_d;
    logic [31:0]       retired_q, retired_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Instruction field decode
    logic [3:0]        op_c;
    logic [1:0]        rs_c, rt_c, rd_c, dest_c;
    logic [DATA_W-1:0] imm_c;
    logic [ADDR_W-1:0] imm_addr_c;
    logic              is_rtype_c;

    // Register-file write port and ALU result
    logic              rf_we_c;
    logic [1:0]        rf_waddr_c;
    logic [DATA_W-1:0] rf_wdata_c;
    logic [DATA_W-1:0] alu_res_c;

    // Memory port, driven purely from the current state
    logic              mem_req_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Field extraction; R-type writes rd, I-type writes rt
    always_comb begin
        op_c       = ir_q[15:12];
        rs_c       = ir_q[11:10];
        rt_c       = ir_q[9:8];
        rd_c       = ir_q[7:6];
        imm_c      = {{(DATA_W-IMM_W){ir_q[7]}}, ir_q[7:0]};
        imm_addr_c = {{(ADDR_W-IMM_W){ir_q[7]}}, ir_q[7:0]};
        is_rtype_c = (op_c <= OP_SLT);
        dest_c     = is_rtype_c ? rd_c : rt_c;
    end

    // ALU on the operands latched in DECODE; slt is a true signed compare
    always_comb begin
        alu_res_c = '0;
        unique case (op_c)
            OP_ADD:  alu_res_c = a_q + b_q;
            OP_SUB:  alu_res_c = a_q - b_q;
            OP_AND:  alu_res_c = a_q & b_q;
            OP_OR:   alu_res_c = a_q | b_q;
            OP_NOR:  alu_res_c = ~(a_q | b_q);
            OP_NAND: alu_res_c = ~(a_q & b_q);
            OP_SLT:  alu_res_c[0] = ($signed(a_q) < $signed(b_q));
            OP_ADDI, OP_LW, OP_SW: alu_res_c = a_q + imm_c;
            default: alu_res_c = '0;
        endcase
    end

    // Next-state, datapath updates and memory port control
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        alu_d       = alu_q;
        a_d         = a_q;
        b_d         = b_q;
        md_d        = md_q;
        halted_d    = halted_q;
        retired_d   = retired_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        rf_we_c     = 1'b0;
        rf_waddr_c  = dest_c;
        rf_wdata_c  = (op_c == OP_LW) ? md_q : alu_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req_c  = 1'b1;
                mem_addr_c = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(2);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = regs_q[rs_c];
                b_d = regs_q[rt_c];
                if (ir_q == HALT_INSN) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_rtype_c || op_c == OP_ADDI) begin
                    alu_d   = alu_res_c;
                    state_d = S_WB;
                end else if (op_c == OP_LW || op_c == OP_SW) begin
                    alu_d   = alu_res_c;
                    state_d = S_MEM;
                end else begin
                    // Branches and NOPs finish here; pc already points past the branch
                    if ((op_c == OP_BEQ && a_q == b_q) || (op_c == OP_BNE && a_q != b_q)) begin
                        pc_d = pc_q + (imm_addr_c << 1);
                    end
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                mem_addr_c = ADDR_W'(alu_q);
                if (op_c == OP_SW) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = b_q;
                end
                if (mem_ready) begin
                    if (op_c == OP_SW) begin
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        md_d    = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c   = (dest_c != 2'd0);
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            alu_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            md_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_q     <= alu_d;
            a_q       <= a_d;
            b_q       <= b_d;
            md_q      <= md_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            if (rf_we_c) begin
                regs_q[rf_waddr_c] <= rf_wdata_c;
            end
        end
    end

    assign mem_req   = mem_req_c;
    assign mem_we    = mem_we_c;
    assign mem_addr  = mem_addr_c;
    assign mem_wdata = mem_wdata_c;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign alu_out   = alu_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a memory model with programmable wait
// states, a store scoreboard and per-transaction logging of the memory port.
module tb_multicycle_cpu;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b1;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] pc, ir, alu_out;
    logic        halted;
    logic [31:0] retired;

    multicycle_cpu #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .ir(ir), .alu_out(alu_out), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] prog [0:255];
    logic [15:0] mem  [0:255];
    wr_t         exp_wr [$];
    int          n_checks = 0, n_pass = 0, n_fail = 0;
    int          cyc = 0;
    int          txn = 0, waited = 0;
    bit          in_txn = 0;
    int          stall_txn = -1, stall_n = 0;
    int          txn_start [0:63];
    int          txn_cycles[0:63];
    logic [15:0] txn_addr  [0:63];
    logic [15:0] txn_alu   [0:63];
    bit          txn_stable[0:63];
    logic [15:0] cur_addr, cur_wdata;
    logic        cur_we;

    assign mem_rdata = mem[mem_addr[8:1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Memory slave: decides ready mid-cycle, logs each transfer, checks stores
    always @(negedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] = prog[i];
            in_txn    = 0;
            txn       = 0;
            mem_ready = 1'b1;
        end else if (mem_req) begin
            if (!in_txn) begin
                in_txn    = 1;
                waited    = 0;
                cur_addr  = mem_addr;
                cur_we    = mem_we;
                cur_wdata = mem_wdata;
                if (txn < 64) begin
                    txn_start[txn]  = cyc;
                    txn_cycles[txn] = 0;
                    txn_addr[txn]   = mem_addr;
                    txn_alu[txn]    = alu_out;
                    txn_stable[txn] = 1;
                end
            end else if (mem_addr !== cur_addr || mem_we !== cur_we ||
                         (mem_we && mem_wdata !== cur_wdata)) begin
                if (txn < 64) txn_stable[txn] = 0;
            end
            if (txn < 64) txn_cycles[txn]++;
            if (txn == stall_txn && waited < stall_n) begin
                mem_ready = 1'b0;
                waited++;
            end else begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    wr_t e;
                    mem[mem_addr[8:1]] = mem_wdata;
                    check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
                    if (exp_wr.size() > 0) begin
                        e = exp_wr.pop_front();
                        check("store_addr", 32'(mem_addr), 32'(e.addr));
                        check("store_data", 32'(mem_wdata), 32'(e.data));
                    end
                end
                txn++;
                in_txn = 0;
            end
        end else begin
            mem_ready = 1'b1;
        end
    end

    task automatic begin_test();
        @(negedge clock);
        reset_n = 1'b0;
        stall_txn = -1;
        stall_n   = 0;
        exp_wr.delete();
        for (int i = 0; i < 256; i++) prog[i] = 16'hFFFF;
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 500) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_halt_reached"}, 32'(halted), 32'd1);
        check({tag, "_stores_drained"}, 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        begin_test();
        repeat (2) @(negedge clock);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_alu", 32'(alu_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", retired, 32'd0);

        // Test 1: addi/addi/and/sub/halt, zero wait states
        prog[0] = 16'h710F;  // addi r1,r0,15
        prog[1] = 16'h7207;  // addi r2,r0,7
        prog[2] = 16'h26C0;  // and  r3,r1,r2
        prog[3] = 16'h16C0;  // sub  r3,r1,r2
        prog[4] = 16'hFFFF;  // halt
        release_reset();
        wait_halt("t1");
        check("t1_pc", 32'(pc), 32'd10);
        check("t1_retired", retired, 32'd4);
        check("t1_ir", 32'(ir), 32'hFFFF);
        check("t1_alu_r1", 32'(txn_alu[1]), 32'd15);
        check("t1_alu_and", 32'(txn_alu[3]), 32'd7);
        check("t1_alu_sub", 32'(txn_alu[4]), 32'd8);
        check("t1_addi_latency", 32'(txn_start[1] - txn_start[0]), 32'd4);
        check("t1_and_latency", 32'(txn_start[3] - txn_start[2]), 32'd4);
        check("t1_txn_count", 32'(txn), 32'd5);
        repeat (5) @(negedge clock);
        check("t1_halt_sticky_req", 32'(mem_req), 32'd0);
        check("t1_halt_sticky_ret", retired, 32'd4);

        // Test 2: slt, including operand pairs whose difference overflows
        begin_test();
        prog[0]  = 16'h8140;  // lw  r1,0x40(r0)
        prog[1]  = 16'h7201;  // addi r2,r0,1
        prog[2]  = 16'h66C0;  // slt r3,r1,r2
        prog[3]  = 16'h9360;  // sw  r3,0x60(r0)
        prog[4]  = 16'h69C0;  // slt r3,r2,r1
        prog[5]  = 16'h9362;  // sw  r3,0x62(r0)
        prog[6]  = 16'h8242;  // lw  r2,0x42(r0)
        prog[7]  = 16'h66C0;  // slt r3,r1,r2
        prog[8]  = 16'h9364;  // sw  r3,0x64(r0)
        prog[9]  = 16'hFFFF;
        prog[32] = 16'h8000;
        prog[33] = 16'h7FFF;
        push_wr(16'h0060, 16'd1);
        push_wr(16'h0062, 16'd0);
        push_wr(16'h0064, 16'd1);
        release_reset();
        wait_halt("t2");
        check("t2_retired", retired, 32'd9);
        check("t2_pc", 32'(pc), 32'd20);

        // Test 3: bne taken backwards, then not taken; beq taken, then not taken
        begin_test();
        prog[0] = 16'h7101;  // addi r1,r0,1
        prog[1] = 16'h7203;  // addi r2,r0,3
        for (int i = 2; i < 8; i++) prog[i] = 16'hC000;  // nop
        prog[8]  = 16'h7AFF;  // addi r2,r2,-1
        prog[9]  = 16'hC000;
        prog[10] = 16'hC000;
        prog[11] = 16'hB6FC;  // bne r1,r2,-4
        prog[12] = 16'hA602;  // beq r1,r2,+2
        prog[13] = 16'h9150;  // skipped
        prog[14] = 16'h9150;  // skipped
        prog[15] = 16'hA47F;  // beq r1,r0,+127 (not taken)
        prog[16] = 16'hFFFF;
        release_reset();
        wait_halt("t3");
        check("t3_bne_pc", 32'(txn_addr[11]), 32'd22);
        check("t3_bne_taken", 32'(txn_addr[12]), 32'd16);
        check("t3_bne_again", 32'(txn_addr[15]), 32'd22);
        check("t3_bne_not_taken", 32'(txn_addr[16]), 32'd24);
        check("t3_beq_taken", 32'(txn_addr[17]), 32'd30);
        check("t3_beq_not_taken", 32'(txn_addr[18]), 32'd32);
        check("t3_nop_latency", 32'(txn_start[3] - txn_start[2]), 32'd3);
        check("t3_br_latency", 32'(txn_start[12] - txn_start[11]), 32'd3);
        check("t3_retired", retired, 32'd18);
        check("t3_pc", 32'(pc), 32'd34);

        // Test 4: lw with three wait states on the data access
        begin_test();
        prog[0] = 16'h0005;  // add r0,r0,r0 and data word 5
        prog[1] = 16'h8100;  // lw r1,0(r0)
        prog[2] = 16'h9150;  // sw r1,0x50(r0)
        prog[3] = 16'hFFFF;
        stall_txn = 2;
        stall_n   = 3;
        push_wr(16'h0050, 16'd5);
        release_reset();
        wait_halt("t4");
        check("t4_lw_addr", 32'(txn_addr[2]), 32'd0);
        check("t4_lw_req_cycles", 32'(txn_cycles[2]), 32'd4);
        check("t4_lw_stable", 32'(txn_stable[2]), 32'd1);
        check("t4_lw_latency", 32'(txn_start[3] - txn_start[1]), 32'd8);
        check("t4_fetch_cycles", 32'(txn_cycles[1]), 32'd1);
        check("t4_retired", retired, 32'd3);

        // Test 5: sw into program space, addi to r0 is dropped
        begin_test();
        prog[0] = 16'h7207;  // addi r2,r0,7
        prog[1] = 16'h9204;  // sw r2,4(r0) overwrites the halt below
        prog[2] = 16'hFFFF;
        prog[3] = 16'h7005;  // addi r0,r0,5
        prog[4] = 16'h9070;  // sw r0,0x70(r0)
        prog[5] = 16'hFFFF;
        push_wr(16'h0004, 16'd7);
        push_wr(16'h0070, 16'd0);
        release_reset();
        wait_halt("t5");
        check("t5_retired", retired, 32'd5);
        check("t5_pc", 32'(pc), 32'd12);
        check("t5_sw_latency", 32'(txn_start[3] - txn_start[1]), 32'd4);

        // Test 6: reset asserted during a stalled fetch
        begin_test();
        prog[0] = 16'h7101;
        prog[1] = 16'h7101;
        prog[2] = 16'h7101;
        prog[3] = 16'hFFFF;
        stall_txn = 3;
        stall_n   = 50;
        release_reset();
        n = 0;
        while (!(txn == 3 && in_txn && waited >= 2) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t6_reached_stall", 32'(n < 200), 32'd1);
        check("t6_pre_req", 32'(mem_req), 32'd1);
        check("t6_pre_addr", 32'(mem_addr), 32'd6);
        check("t6_pre_retired", retired, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_req_drop", 32'(mem_req), 32'd0);
        check("t6_pc", 32'(pc), 32'd0);
        check("t6_retired", retired, 32'd0);
        check("t6_alu", 32'(alu_out), 32'd0);
        stall_txn = -1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("t6_idle_after_release", 32'(mem_req), 32'd0);
        @(posedge clock);
        #1;
        check("t6_fetch_restart_req", 32'(mem_req), 32'd1);
        check("t6_fetch_restart_addr", 32'(mem_addr), 32'd0);
        wait_halt("t6");
        check("t6_final_retired", retired, 32'd3);
        check("t6_final_pc", 32'(pc), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
